// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller for the 0x8000_00xx region: UART TX FIFO, single-entry
// RX buffer, cycle/instruction counters, and one-cycle-latency load data.
module mmio_io_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        tx_overflow
);
    localparam int PTR_W = $clog2(TX_DEPTH);

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXD    = 32'h8000_0004;
    localparam logic [31:0] A_TXD    = 32'h8000_0008;
    localparam logic [31:0] A_CYC    = 32'h8000_0010;
    localparam logic [31:0] A_INS    = 32'h8000_0014;
    localparam logic [31:0] A_CLR    = 32'h8000_0018;

    logic [7:0]       mem_r [TX_DEPTH];
    logic [PTR_W:0]   rd_ptr_r;
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_nxt_s;
    logic [PTR_W:0]   wr_nxt_s;
    logic             tx_full_s;
    logic             tx_push_s;
    logic             tx_drop_s;
    logic             tx_pop_s;
    logic [7:0]       head_nxt_s;
    logic             tx_valid_r;
    logic [7:0]       tx_data_r;
    logic             tx_overflow_r;
    logic             rx_full_r;
    logic             rx_ready_r;
    logic [7:0]       rx_byte_r;
    logic             rx_pop_s;
    logic             rx_cap_s;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [CNT_W-1:0] ins_cnt_r;
    logic             clr_s;
    logic [31:0]      rd_mux_s;
    logic [31:0]      rdata_r;
    logic             unused_s;

    assign unused_s = ^wdata[31:8];

    // Decode strobes and next FIFO pointers; the registered head must track a push into an emptying FIFO.
    always_comb begin
        tx_full_s = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                    (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
        tx_push_s = io_wr && (addr == A_TXD) && !tx_full_s;
        tx_drop_s = io_wr && (addr == A_TXD) && tx_full_s;
        tx_pop_s  = tx_valid_r && tx_ready;
        rd_nxt_s  = tx_pop_s  ? rd_ptr_r + (PTR_W+1)'(1'b1) : rd_ptr_r;
        wr_nxt_s  = tx_push_s ? wr_ptr_r + (PTR_W+1)'(1'b1) : wr_ptr_r;
        if (tx_push_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = wdata[7:0];
        end else begin
            head_nxt_s = mem_r[rd_nxt_s[PTR_W-1:0]];
        end
        clr_s    = io_wr && (addr == A_CLR);
        rx_pop_s = io_rd && (addr == A_RXD) && rx_full_r;
        rx_cap_s = rx_valid && rx_ready_r;
    end

    // Load data mux, built from state at the start of the cycle.
    always_comb begin
        case (addr)
            A_STATUS: rd_mux_s = {29'h0, tx_overflow_r, rx_full_r, !tx_full_s};
            A_RXD:    rd_mux_s = {24'h0, rx_byte_r};
            A_CYC:    rd_mux_s = 32'(cyc_cnt_r);
            A_INS:    rd_mux_s = 32'(ins_cnt_r);
            default:  rd_mux_s = 32'h0;
        endcase
    end

    // TX FIFO storage, pointers, registered head and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            tx_valid_r    <= 1'b0;
            tx_data_r     <= 8'h00;
            tx_overflow_r <= 1'b0;
        end else begin
            if (tx_push_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata[7:0];
            end
            rd_ptr_r   <= rd_nxt_s;
            wr_ptr_r   <= wr_nxt_s;
            tx_valid_r <= (wr_nxt_s != rd_nxt_s);
            tx_data_r  <= head_nxt_s;
            if (clr_s) begin
                tx_overflow_r <= 1'b0;
            end else if (tx_drop_s) begin
                tx_overflow_r <= 1'b1;
            end
        end
    end

    // Single-entry RX buffer; capture and pop are mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full_r  <= 1'b0;
            rx_ready_r <= 1'b1;
            rx_byte_r  <= 8'h00;
        end else begin
            if (rx_cap_s) begin
                rx_byte_r  <= rx_data;
                rx_full_r  <= 1'b1;
                rx_ready_r <= 1'b0;
            end else if (rx_pop_s) begin
                rx_full_r  <= 1'b0;
                rx_ready_r <= 1'b1;
            end
        end
    end

    // Free-running cycle counter and retired-instruction counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_r <= '0;
            ins_cnt_r <= '0;
        end else if (clr_s) begin
            cyc_cnt_r <= '0;
            ins_cnt_r <= '0;
        end else begin
            cyc_cnt_r <= cyc_cnt_r + CNT_W'(1'b1);
            if (inst_retire) begin
                ins_cnt_r <= ins_cnt_r + CNT_W'(1'b1);
            end
        end
    end

    // Registered load data, held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0;
        end else if (io_rd) begin
            rdata_r <= rd_mux_s;
        end
    end

    assign rdata       = rdata_r;
    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign rx_ready    = rx_ready_r;
    assign tx_overflow = tx_overflow_r;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed self-checking bench for mmio_io_ctrl: one task per feature, inline comparisons.
module tb_mmio_io_ctrl;
    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXD    = 32'h8000_0004;
    localparam logic [31:0] A_TXD    = 32'h8000_0008;
    localparam logic [31:0] A_CYC    = 32'h8000_0010;
    localparam logic [31:0] A_INS    = 32'h8000_0014;
    localparam logic [31:0] A_CLR    = 32'h8000_0018;
    localparam logic [31:0] A_BAD    = 32'h8000_0020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        inst_retire;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;

    mmio_io_ctrl #(.TX_DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .io_rd(io_rd), .io_wr(io_wr), .addr(addr),
        .wdata(wdata), .inst_retire(inst_retire), .rdata(rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        io_wr = 1'b1; addr = a; wdata = d;
        step();
        io_wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic do_read(input logic [31:0] a);
        io_rd = 1'b1; addr = a;
        step();
        io_rd = 1'b0; addr = 32'h0;
    endtask

    task automatic test_reset();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want %h", rdata, 32'h0); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready got %b want 1", rx_ready); end
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", tx_overflow); end
        rst_n = 1'b1;
        step();
        do_read(A_STATUS);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL rst_status got %h want %h", rdata, 32'h1); end
        checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL rst_flags got %b%b want 01", tx_valid, rx_ready); end
    endtask

    task automatic test_tx_order();
        logic [7:0] exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        tx_ready = 1'b0;
        do_write(A_TXD, 32'h0000_0041);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_first_valid got %b want 1", tx_valid); end
        do_write(A_TXD, 32'hFFFF_FF42);
        do_write(A_TXD, 32'h0000_0043);
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL tx_head got %h want 41", tx_data); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                errors++; $display("FAIL tx_order[%0d] got %b/%h want 1/%h", i, tx_valid, tx_data, exp[i]);
            end
            step();
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty got %b want 0", tx_valid); end
    endtask

    task automatic test_overflow();
        int n;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_write(A_TXD, 32'h10 + 32'(i));
        end
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", tx_overflow); end
        do_read(A_STATUS);
        checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL ovf_status got %h want %h", rdata, 32'h4); end
        do_write(A_CLR, 32'hDEAD_BEEF);
        do_read(A_STATUS);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL ovf_clr_status got %h want %h", rdata, 32'h0); end
        tx_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (tx_valid) begin
                checks++;
                if (tx_data !== 8'(8'h10 + n)) begin
                    errors++; $display("FAIL drain[%0d] got %h want %h", n, tx_data, 8'(8'h10 + n));
                end
                n++;
            end
            step();
        end
        tx_ready = 1'b0;
        checks++; if (n != 8) begin errors++; $display("FAIL drain_count got %0d want 8", n); end
    endtask

    task automatic test_rx();
        rx_data = 8'h5A; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_low got %b want 0", rx_ready); end
        do_read(A_STATUS);
        checks++; if (rdata !== 32'h3) begin errors++; $display("FAIL rx_status got %h want %h", rdata, 32'h3); end
        // Pop and offer a new byte in the same cycle; it must wait a cycle.
        io_rd = 1'b1; addr = A_RXD; rx_data = 8'h33; rx_valid = 1'b1;
        step();
        io_rd = 1'b0; addr = 32'h0;
        checks++; if (rdata !== 32'h5A) begin errors++; $display("FAIL rx_pop_data got %h want %h", rdata, 32'h5A); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after_pop got %b want 1", rx_ready); end
        step();
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_second_capture got %b want 0", rx_ready); end
        do_read(A_RXD);
        checks++; if (rdata !== 32'h33) begin errors++; $display("FAIL rx_second_data got %h want %h", rdata, 32'h33); end
        do_read(A_RXD);
        checks++; if (rdata !== 32'h33 || rx_ready !== 1'b1) begin errors++; $display("FAIL rx_stale got %h/%b want 33/1", rdata, rx_ready); end
    endtask

    task automatic test_counters();
        do_write(A_CLR, 32'h0);
        for (int i = 0; i < 20; i++) begin
            inst_retire = (i % 2 == 0);
            step();
        end
        inst_retire = 1'b0;
        do_read(A_INS);
        checks++; if (rdata !== 32'd10) begin errors++; $display("FAIL ins_count got %0d want 10", rdata); end
        io_wr = 1'b1; addr = A_CLR; inst_retire = 1'b1;
        step();
        io_wr = 1'b0; addr = 32'h0; inst_retire = 1'b0;
        step();
        do_read(A_CYC);
        checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL cyc_after_clr got %0d want 1", rdata); end
        do_read(A_INS);
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL ins_after_clr got %0d want 0", rdata); end
    endtask

    task automatic test_wrap_unmapped();
        force dut.cyc_cnt_r = 32'hFFFF_FFFE;
        step();
        release dut.cyc_cnt_r;
        do_read(A_CYC);
        checks++; if (rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cyc_pre_wrap got %h want FFFFFFFE", rdata); end
        do_read(A_CYC);
        checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_max got %h want FFFFFFFF", rdata); end
        do_read(A_CYC);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL cyc_wrap got %h want 00000000", rdata); end
        do_write(A_BAD, 32'h0000_0077);
        do_read(A_BAD);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", rdata); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL unmapped_write got %b want 0", tx_valid); end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        do_write(A_TXD, 32'h55);
        do_write(A_TXD, 32'h66);
        io_rd = 1'b1; addr = A_STATUS;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_valid got %b want 0", tx_valid); end
        step();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", rdata); end
        io_rd = 1'b0; addr = 32'h0;
        rst_n = 1'b1;
        step();
        step();
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_fifo got %b/%h want 0/00", tx_valid, tx_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; io_rd = 1'b0; io_wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        inst_retire = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        step();
        step();
        test_reset();
        test_tx_order();
        test_overflow();
        test_rx();
        test_counters();
        test_wrap_unmapped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Memory-mapped I/O controller in the memory stage, downstream of the memory-stage control decode. It consumes I/O read/write strobes, addresses, and store data for the 0x8000_00xx region. It services a UART byte stream through a TX FIFO and a single-entry RX buffer, and maintains cycle and retired-instruction counters. Load data returns with one-cycle latency, aligned with synchronous DMEM reads, for the writeback mux.

Parameters:
TX_DEPTH, 8, TX FIFO entries; power of 2, minimum 2
CNT_W, 32, width of the cycle and instruction counters; reads zero-extend to 32 bits

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
io_rd  in  1  load to I/O region this cycle
io_wr  in  1  store to I/O region this cycle
addr  in  32  byte address of the access
wdata  in  32  store data; only [7:0] is used for TX
inst_retire  in  1  one pulse per retired instruction
rdata  out  32  registered load data
tx_data  out  8  byte to the UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART transmitter accepts the byte
rx_data  in  8  byte from the UART receiver
rx_valid  in  1  rx_data valid
rx_ready  out  1  buffer can accept an RX byte
tx_overflow  out  1  sticky flag: a TX store was dropped

Behaviour:
- Reset (rst_n low, asynchronous), all state cleared:
  - rdata=0, tx_valid=0, tx_data=0
  - TX FIFO empty, RX buffer empty, rx_ready=1
  - both counters 0, tx_overflow=0
- Address map (word addresses; any other address: reads return 0, writes ignored):
  - 0x80000000 R: status = {29'b0, tx_overflow, rx_full, tx_not_full}
  - 0x80000004 R: {24'b0, rx_byte}; a read while rx_full pops the buffer
  - 0x80000008 W: pushes wdata[7:0] into the TX FIFO
  - 0x80000010 R: cycle counter
  - 0x80000014 R: instruction counter
  - 0x80000018 W: clears both counters and tx_overflow; data ignored
- Read latency:
  - rdata updates at the clock edge ending the cycle in which io_rd=1.
  - Value returned is the state sampled at the start of that cycle, before same-cycle updates.
  - rdata holds its value when io_rd=0.
- If io_rd and io_wr are both high, both are processed; the read sees pre-write state.
- TX FIFO:
  - tx_valid = !empty; tx_data = head entry, registered output.
  - Pop on tx_valid && tx_ready.
  - Push to an empty FIFO: tx_valid rises the next cycle; no combinational bypass.
  - Fullness is evaluated at the start of the cycle. A push while full is dropped even if a pop occurs in the same cycle, and sets tx_overflow.
  - Simultaneous push and pop when not full: occupancy unchanged, order preserved.
  - Pointers are log2(TX_DEPTH)+1 bits so full and empty are distinguishable; wrap-around is seamless.
- RX buffer:
  - rx_ready = !rx_full.
  - Capture rx_data on rx_valid && rx_ready; rx_full=1 next cycle.
  - A read of 0x80000004 with rx_full=1 clears rx_full next cycle. A new byte is accepted no earlier than the cycle after the pop (rx_ready is low during the pop cycle).
  - A read of 0x80000004 with rx_full=0 returns the stale rx_byte and changes no state.
- Counters:
  - Cycle counter increments every cycle.
  - Instruction counter increments on inst_retire.
  - Both wrap modulo 2^CNT_W.
  - A clear write has priority over increments in the same cycle: both counters are 0 at the next edge.
- Reset mid-operation: FIFO contents discarded, tx_valid drops immediately (asynchronous), and an in-flight read returns 0.

Test Plan:
- Reset, then read 0x80000000 -> rdata=0x00000001 one cycle later; tx_valid=0, rx_ready=1.
- Write 0x41, 0x42, 0x43 to 0x80000008 with tx_ready=0 -> tx_valid=1, tx_data=0x41. Raise tx_ready for 3 cycles -> bytes 0x41, 0x42, 0x43 in order, then tx_valid=0.
- 9 writes with tx_ready=0 (TX_DEPTH=8) -> 9th dropped, status read = 0x00000004. Write 0x80000018 -> status = 0x00000000; drain yields exactly 8 bytes.
- Drive rx_valid with 0x5A -> rx_ready=0 next cycle, status=0x00000003. Read 0x80000004 -> rdata=0x0000005A and rx_ready=1 next cycle. Offer 0x33 during the pop cycle -> not accepted until the following cycle.
- Pulse inst_retire 10 times over 20 cycles, then read 0x80000014 -> 10. Write 0x80000018 with inst_retire=1 in the same cycle -> next read of 0x80000010 = 1 and of 0x80000014 = 0 (counts since clear).
- Preload the cycle counter near 0xFFFFFFFF (force) -> wraps to 0; read of an unmapped address 0x80000020 -> rdata=0.
